// File: rtl/aes_bus_if.sv
// Register-bus bundle between the AES host initiator and the AES register block.
// The shared 32-bit data wire resolves here from each side's drive value and enable,
// so the data lines float whenever neither side is driving.
interface aes_bus_if;
  logic        CS;
  logic        RW;
  logic        adress;
  logic [1:0]  word_sel;
  logic        initiate;
  logic        ready;

  logic [0:31] data_m;
  logic        data_oe;
  logic [0:31] data_s;
  logic        slave_oe;
  wire  [0:31] data;

  // Master drives only on write cycles; slave drives only on read cycles.
  assign data = data_oe  ? data_m :
                slave_oe ? data_s : 'z;

  modport master (
    output CS, RW, adress, word_sel, initiate, data_m, data_oe,
    input  ready, data
  );

  modport slave (
    input  CS, RW, adress, word_sel, initiate, data,
    output ready, data_s, slave_oe
  );
endinterface

// File: rtl/aes_bus_master.sv
// Host-side initiator for the AES register block: writes a latched plaintext and key
// as four 32-bit words each, pulses initiate, waits (bounded) for ready, then reads
// the ciphertext back in four words and presents it with a one-cycle valid pulse.
module aes_bus_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] message_in,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic [0:127] result,
  output logic         result_valid,
  output logic         error,
  aes_bus_if.master    bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MSG, S_WR_KEY, S_INIT, S_WAIT, S_RD, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [0:127]  msg_q, msg_d;
  logic [0:127]  key_q, key_d;
  logic [0:95]   rbuf_q, rbuf_d;
  logic [0:127]  result_q, result_d;
  logic          cs_q, cs_d;
  logic          rw_q, rw_d;
  logic          adr_q, adr_d;
  logic [1:0]    wsel_q, wsel_d;
  logic          init_q, init_d;
  logic          oe_q, oe_d;
  logic [0:31]   wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;
  logic [6:0]    widx;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      rbuf_q   <= '0;
      result_q <= '0;
      cs_q     <= 1'b0;
      rw_q     <= 1'b0;
      adr_q    <= 1'b0;
      wsel_q   <= '0;
      init_q   <= 1'b0;
      oe_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      rbuf_q   <= rbuf_d;
      result_q <= result_d;
      cs_q     <= cs_d;
      rw_q     <= rw_d;
      adr_q    <= adr_d;
      wsel_q   <= wsel_d;
      init_q   <= init_d;
      oe_q     <= oe_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  // Next state, then outputs decoded from the destination state so they register in step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    msg_d    = msg_q;
    key_d    = key_q;
    rbuf_d   = rbuf_q;
    result_d = result_q;
    err_d    = 1'b0;
    cs_d     = 1'b0;
    rw_d     = 1'b0;
    adr_d    = 1'b0;
    wsel_d   = '0;
    init_d   = 1'b0;
    oe_d     = 1'b0;
    wdata_d  = '0;
    busy_d   = 1'b0;
    rv_d     = 1'b0;
    widx     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR_MSG;
          cnt_d   = '0;
          msg_d   = message_in;
          key_d   = key_in;
        end
      end
      S_WR_MSG: begin
        if (cnt_q == 2'd3) begin
          state_d = S_WR_KEY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR_KEY: begin
        if (cnt_q == 2'd3) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_INIT: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (bus.ready) begin
          state_d = S_RD;
          cnt_d   = '0;
        end else if (timer_q == T_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RD: begin
        // Last word lands directly in result together with the buffered first three.
        if (cnt_q == 2'd3) begin
          result_d = {rbuf_q, bus.data};
          state_d  = S_DONE;
          cnt_d    = '0;
        end else begin
          rbuf_d[{cnt_q, 5'd0} +: 32] = bus.data;
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    widx = {cnt_d, 5'd0};
    unique case (state_d)
      S_WR_MSG: begin
        cs_d    = 1'b1;
        rw_d    = 1'b1;
        oe_d    = 1'b1;
        wsel_d  = cnt_d;
        wdata_d = msg_d[widx +: 32];
      end
      S_WR_KEY: begin
        cs_d    = 1'b1;
        rw_d    = 1'b1;
        adr_d   = 1'b1;
        oe_d    = 1'b1;
        wsel_d  = cnt_d;
        wdata_d = key_d[widx +: 32];
      end
      S_INIT: init_d = 1'b1;
      S_RD: begin
        cs_d   = 1'b1;
        wsel_d = cnt_d;
      end
      S_DONE: rv_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign error        = err_q;
  assign bus.CS       = cs_q;
  assign bus.RW       = rw_q;
  assign bus.adress   = adr_q;
  assign bus.word_sel = wsel_q;
  assign bus.initiate = init_q;
  assign bus.data_m   = wdata_q;
  assign bus.data_oe  = oe_q;

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master: one instance with the default timeout and one
// with TIMEOUT=16, each with a simple register-block slave model.
`timescale 1ns/1ps
module tb_aes_bus_master;

  localparam logic [0:127] MSG1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] MSG2 = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [0:127] KEY2 = 128'hfedcba98765432100f1e2d3c4b5a6978;
  localparam logic [0:127] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, start_b;
  logic [0:127] msg, key;
  logic busy_a, busy_b, rv_a, rv_b, err_a, err_b;
  logic [0:127] result_a, result_b;
  logic [0:127] ct_a, ct_b;

  int checks = 0;
  int failures = 0;

  logic [34:0] wq_a[$];
  int init_cnt_a = 0;
  int rv_cnt_a = 0;
  int rv_cnt_b = 0;

  logic [31:0] mw [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] kw [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};

  always #5 clk = ~clk;

  aes_bus_if bus_a ();
  aes_bus_if bus_b ();

  aes_bus_master dut_a (
    .clk(clk), .reset(reset_n), .start(start_a), .message_in(msg), .key_in(key),
    .busy(busy_a), .result(result_a), .result_valid(rv_a), .error(err_a), .bus(bus_a)
  );

  aes_bus_master #(.TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset_n), .start(start_b), .message_in(msg), .key_in(key),
    .busy(busy_b), .result(result_b), .result_valid(rv_b), .error(err_b), .bus(bus_b)
  );

  // Slave models: return the ciphertext word combinationally during read cycles.
  always_comb begin
    bus_a.slave_oe = bus_a.CS && !bus_a.RW;
    bus_a.data_s   = ct_a[{bus_a.word_sel, 5'd0} +: 32];
    bus_b.slave_oe = bus_b.CS && !bus_b.RW;
    bus_b.data_s   = ct_b[{bus_b.word_sel, 5'd0} +: 32];
  end

  // Bus monitor: logs write cycles and counts pulses on instance A / B.
  always @(posedge clk) begin
    if (bus_a.CS && bus_a.RW) wq_a.push_back({bus_a.adress, bus_a.word_sel, bus_a.data});
    if (bus_a.initiate) init_cnt_a++;
    if (rv_a) rv_cnt_a++;
    if (rv_b) rv_cnt_b++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_writes(input int base);
    logic [34:0] exp;
    check("wr_count", 128'(wq_a.size() - base), 128'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < 4) exp = {1'b0, 2'(i), mw[i]};
      else       exp = {1'b1, 2'(i - 4), kw[i - 4]};
      check($sformatf("wr_word%0d", i), 128'(wq_a[base + i]), 128'(exp));
    end
  endtask

  initial begin
    int base, i0, r0, lat, errk, errn;
    logic found, be;

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    msg = '0;
    key = '0;
    bus_a.ready = 1'b0;
    bus_b.ready = 1'b0;
    ct_a = CT1;
    ct_b = CT1;
    step(2);
    reset_n = 1'b1;
    step(5);

    // Reset / idle state.
    check("idle_a", 128'({busy_a, bus_a.CS, bus_a.RW, bus_a.adress, bus_a.word_sel,
                          bus_a.initiate, rv_a, err_a, bus_a.data_oe}), 128'(0));
    check("idle_b", 128'({busy_b, bus_b.CS, bus_b.RW, bus_b.adress, bus_b.word_sel,
                          bus_b.initiate, rv_b, err_b, bus_b.data_oe}), 128'(0));
    check("idle_result_a", 128'(result_a), 128'(0));
    check("idle_result_b", 128'(result_b), 128'(0));

    // Full transaction, ready 20 cycles after initiate; inputs change after start.
    base = wq_a.size();
    i0 = init_cnt_a;
    r0 = rv_cnt_a;
    msg = MSG1;
    key = KEY1;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    msg = MSG2;
    key = KEY2;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus_a.initiate) found = 1'b1;
      else step(1);
    end
    check("t1_initiate_seen", 128'(found), 128'(1));
    check_writes(base);
    step(20);
    bus_a.ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1);
      if (rv_a) found = 1'b1;
    end
    check("t1_rv_seen", 128'(found), 128'(1));
    check("t1_result", 128'(result_a), 128'(CT1));
    bus_a.ready = 1'b0;
    step(1);
    check("t1_rv_one_cycle", 128'(rv_a), 128'(0));
    check("t1_busy_after", 128'(busy_a), 128'(0));
    check("t1_result_hold", 128'(result_a), 128'(CT1));
    check("t1_initiate_count", 128'(init_cnt_a - i0), 128'(1));
    check("t1_rv_count", 128'(rv_cnt_a - r0), 128'(1));

    // Ready already high: result_valid 15 cycles after the start cycle.
    ct_a = CT2;
    bus_a.ready = 1'b1;
    start_a = 1'b1;
    lat = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (k == 1) begin
        start_a = 1'b0;
        check("t2_first_write", 128'({bus_a.CS, bus_a.RW, bus_a.adress, bus_a.word_sel,
                                      bus_a.data_oe, busy_a}), 128'(7'b1100011));
      end
      if (rv_a && lat == 0) lat = k;
    end
    check("t2_latency", 128'(lat), 128'(15));
    check("t2_result", 128'(result_a), 128'(CT2));
    bus_a.ready = 1'b0;

    // Starts during WR_KEY and WAIT with different data are ignored.
    ct_a = CT1;
    step(2);
    base = wq_a.size();
    i0 = init_cnt_a;
    r0 = rv_cnt_a;
    msg = MSG1;
    key = KEY1;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(5);
    check("t3_in_wr_key", 128'({bus_a.CS, bus_a.RW, bus_a.adress}), 128'(3'b111));
    msg = MSG2;
    key = KEY2;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus_a.initiate) found = 1'b1;
      else step(1);
    end
    check("t3_initiate_seen", 128'(found), 128'(1));
    step(2);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    bus_a.ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1);
      if (rv_a) found = 1'b1;
    end
    check("t3_rv_seen", 128'(found), 128'(1));
    check("t3_result", 128'(result_a), 128'(CT1));
    bus_a.ready = 1'b0;
    step(25);
    check_writes(base);
    check("t3_initiate_count", 128'(init_cnt_a - i0), 128'(1));
    check("t3_rv_count", 128'(rv_cnt_a - r0), 128'(1));
    check("t3_busy_after", 128'(busy_a), 128'(0));

    // Instance B: one good run, then a timeout with ready never asserted.
    bus_b.ready = 1'b1;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1);
      if (rv_b) found = 1'b1;
    end
    check("t4_prev_rv_seen", 128'(found), 128'(1));
    check("t4_prev_result", 128'(result_b), 128'(CT1));
    bus_b.ready = 1'b0;
    step(2);
    r0 = rv_cnt_b;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus_b.initiate) found = 1'b1;
      else step(1);
    end
    check("t4_initiate_seen", 128'(found), 128'(1));
    errk = 0;
    errn = 0;
    be = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (err_b) begin
        errn++;
        if (errk == 0) begin
          errk = k;
          be = busy_b;
        end
      end
    end
    check("t4_error_cycle", 128'(errk), 128'(17));
    check("t4_error_pulses", 128'(errn), 128'(1));
    check("t4_busy_at_error", 128'(be), 128'(0));
    check("t4_busy_after", 128'(busy_b), 128'(0));
    check("t4_no_rv", 128'(rv_cnt_b - r0), 128'(0));
    check("t4_result_kept", 128'(result_b), 128'(CT1));

    // Asynchronous reset during read word 2, then a clean run.
    ct_a = CT2;
    bus_a.ready = 1'b1;
    r0 = rv_cnt_a;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(12);
    check("t5_in_rd_word2", 128'({bus_a.CS, bus_a.RW, bus_a.word_sel, bus_a.data_oe}),
          128'(5'b10100));
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_reset_outputs", 128'({busy_a, bus_a.CS, bus_a.RW, bus_a.adress, bus_a.word_sel,
                                    bus_a.initiate, rv_a, err_a, bus_a.data_oe}), 128'(0));
    check("t5_reset_result", 128'(result_a), 128'(0));
    step(1);
    reset_n = 1'b1;
    step(1);
    check("t5_no_rv", 128'(rv_cnt_a - r0), 128'(0));
    start_a = 1'b1;
    lat = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (k == 1) start_a = 1'b0;
      if (rv_a && lat == 0) lat = k;
    end
    check("t5_latency", 128'(lat), 128'(15));
    check("t5_result", 128'(result_a), 128'(CT2));
    bus_a.ready = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
